nf_ahb_arbiter: RTL and testbench

NF_AHB_ARBITER -- requirements
Module: nf_ahb_arbiter

---
 rtl/nf_ahb_pkg.sv | 47 ++++
 rtl/nf_ahb_rr_sel.sv | 27 ++
 rtl/nf_register.sv | 17 +
 rtl/nf_ahb_arbiter.sv | 120 ++++++++++++
 tb/tb_nf_ahb_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/nf_ahb_pkg.sv
// Shared AHB encodings and helpers for the nf_ahb arbiter slice.
package nf_ahb_pkg;

    localparam int unsigned addr_w = 32;
    localparam int unsigned data_w = 32;
    localparam int unsigned beat_w = 4;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Beats remaining after the NONSEQ of a fixed-length burst; 0 for SINGLE/INCR.
    function automatic logic [beat_w-1:0] burst_beats(input logic [2:0] hburst);
        logic [beat_w-1:0] n;
        n = '0;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  n = beat_w'(3);
            HBURST_WRAP8,  HBURST_INCR8:  n = beat_w'(7);
            HBURST_WRAP16, HBURST_INCR16: n = beat_w'(15);
            default:                      n = '0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/nf_ahb_rr_sel.sv
// Round-robin search starting one past the current owner; owner checked last.
module nf_ahb_rr_sel #(
    parameter  int unsigned master_c = 2,
    localparam int unsigned mw       = $clog2(master_c)
) (
    input  logic [master_c-1:0] req,
    input  logic [mw-1:0]       cur,
    output logic [mw-1:0]       sel_c,
    output logic                any_c
);

    logic [mw-1:0] idx;

    always_comb begin
        sel_c = cur;
        any_c = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= master_c; i++) begin
            idx = mw'((32'(cur) + i) % master_c);
            if (!any_c && req[idx]) begin
                sel_c = idx;
                any_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nf_register.sv
// Enabled register with synchronous active-high reset to zero.
module nf_register #(
    parameter int unsigned width = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)     q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/nf_ahb_arbiter.sv
// Round-robin AHB arbiter muxing several masters onto one nf_ahb_router master port,
// with burst locking for fixed-length and INCR bursts.
module nf_ahb_arbiter
    import nf_ahb_pkg::*;
#(
    parameter  int unsigned master_c = 2,
    localparam int unsigned mw       = $clog2(master_c)
) (
    input  logic                hclk,
    input  logic                hreset,
    input  logic [master_c-1:0] hbusreq_m,
    input  logic [addr_w-1:0]   haddr_m  [master_c],
    input  logic [data_w-1:0]   hwdata_m [master_c],
    input  logic [master_c-1:0] hwrite_m,
    input  logic [1:0]          htrans_m [master_c],
    input  logic [2:0]          hsize_m  [master_c],
    input  logic [2:0]          hburst_m [master_c],
    output logic [master_c-1:0] hgrant_m,
    output logic [data_w-1:0]   hrdata_m,
    output logic [1:0]          hresp_m,
    output logic                hready_m,
    output logic [mw-1:0]       hmaster,
    output logic [addr_w-1:0]   haddr,
    output logic [data_w-1:0]   hwdata,
    output logic                hwrite,
    output logic [1:0]          htrans,
    output logic [2:0]          hsize,
    output logic [2:0]          hburst,
    input  logic [data_w-1:0]   hrdata,
    input  logic [1:0]          hresp,
    input  logic                hready
);

    arb_state_e        state_q;
    logic [beat_w-1:0] beat_q;
    logic [beat_w-1:0] beat_nxt;
    logic              hold_nxt;
    logic              incr_act;
    logic              req_own;
    logic              grant_move;
    logic [mw-1:0]     data_owner_q;
    logic [mw-1:0]     rr_sel;
    logic              rr_any;

    // Address phase follows the current owner, data phase the previous one.
    assign haddr  = haddr_m[hmaster];
    assign hwrite = hwrite_m[hmaster];
    assign htrans = htrans_m[hmaster];
    assign hsize  = hsize_m[hmaster];
    assign hburst = hburst_m[hmaster];
    assign hwdata = hwdata_m[data_owner_q];

    assign hrdata_m = hrdata;
    assign hresp_m  = hresp;
    assign hready_m = hready;

    nf_register #(.width(mw)) u_data_owner (
        .clk (hclk),
        .rst (hreset),
        .en  (hready),
        .d   (hmaster),
        .q   (data_owner_q)
    );

    nf_ahb_rr_sel #(.master_c(master_c)) u_rr_sel (
        .req   (hbusreq_m),
        .cur   (hmaster),
        .sel_c (rr_sel),
        .any_c (rr_any)
    );

    assign req_own  = hbusreq_m[hmaster];
    // LOCK with an empty counter can only mean an INCR burst is holding the bus.
    assign incr_act = (state_q == LOCK) && (beat_q == '0);

    // Hold is evaluated as it will be after the transfer on the bus is accepted.
    always_comb begin
        beat_nxt = beat_q;
        hold_nxt = (state_q == LOCK);
        if (!hready && (hresp == HRESP_ERROR)) begin
            beat_nxt = '0;
            hold_nxt = 1'b0;
        end else if (hready) begin
            case (htrans)
                HTRANS_NONSEQ: begin
                    beat_nxt = burst_beats(hburst);
                    hold_nxt = (beat_nxt != '0) || ((hburst == HBURST_INCR) && req_own);
                end
                HTRANS_SEQ: begin
                    beat_nxt = (beat_q == '0) ? '0 : beat_q - beat_w'(1);
                    hold_nxt = (beat_nxt != '0) || (incr_act && req_own);
                end
                HTRANS_IDLE: begin
                    beat_nxt = '0;
                    hold_nxt = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign grant_move = hready && !hold_nxt && rr_any;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q  <= ARB;
            beat_q   <= '0;
            hmaster  <= '0;
            hgrant_m <= master_c'(1);
        end else begin
            state_q <= hold_nxt ? LOCK : ARB;
            beat_q  <= beat_nxt;
            if (grant_move) begin
                hmaster  <= rr_sel;
                hgrant_m <= master_c'(1) << rr_sel;
            end
        end
    end

endmodule

// File: tb/tb_nf_ahb_arbiter.sv
// Directed bench for nf_ahb_arbiter with two masters.
module tb_nf_ahb_arbiter;
    import nf_ahb_pkg::*;

    localparam int unsigned MC = 2;

    logic          hclk = 1'b0;
    logic          hreset;
    logic [MC-1:0] hbusreq_m;
    logic [31:0]   haddr_m  [MC];
    logic [31:0]   hwdata_m [MC];
    logic [MC-1:0] hwrite_m;
    logic [1:0]    htrans_m [MC];
    logic [2:0]    hsize_m  [MC];
    logic [2:0]    hburst_m [MC];
    logic [MC-1:0] hgrant_m;
    logic [31:0]   hrdata_m;
    logic [1:0]    hresp_m;
    logic          hready_m;
    logic          hmaster;
    logic [31:0]   haddr;
    logic [31:0]   hwdata;
    logic          hwrite;
    logic [1:0]    htrans;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic [31:0]   hrdata;
    logic [1:0]    hresp;
    logic          hready;

    int checks = 0;
    int fails  = 0;

    nf_ahb_arbiter #(.master_c(MC)) dut (
        .hclk(hclk), .hreset(hreset), .hbusreq_m(hbusreq_m),
        .haddr_m(haddr_m), .hwdata_m(hwdata_m), .hwrite_m(hwrite_m),
        .htrans_m(htrans_m), .hsize_m(hsize_m), .hburst_m(hburst_m),
        .hgrant_m(hgrant_m), .hrdata_m(hrdata_m), .hresp_m(hresp_m),
        .hready_m(hready_m), .hmaster(hmaster), .haddr(haddr),
        .hwdata(hwdata), .hwrite(hwrite), .htrans(htrans), .hsize(hsize),
        .hburst(hburst), .hrdata(hrdata), .hresp(hresp), .hready(hready)
    );

    always #5 hclk = ~hclk;

    function automatic logic [31:0] wd(input int m, input logic [31:0] a);
        return {8'hD0 + 8'(m), a[23:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int m, input logic [1:0] tr, input logic [2:0] bu, input logic [31:0] a);
        htrans_m[m] = tr;
        hburst_m[m] = bu;
        haddr_m[m]  = a;
        hwdata_m[m] = wd(m, a);
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    initial begin
        hreset    = 1'b1;
        hbusreq_m = '0;
        hwrite_m  = '1;
        hrdata    = 32'hCAFE_F00D;
        hresp     = HRESP_OKAY;
        hready    = 1'b1;
        for (int m = 0; m < int'(MC); m++) begin
            hsize_m[m] = 3'b010;
            drv(m, HTRANS_IDLE, HBURST_SINGLE, 32'h0000_0000);
        end
        tick();
        tick();
        chk("rst_grant", 32'(hgrant_m), 32'h1);
        chk("rst_hmaster", 32'(hmaster), 32'h0);
        chk("rst_beat", 32'(dut.beat_q), 32'h0);
        chk("rst_state", 32'(dut.state_q), 32'(ARB));
        chk("rst_hrdata", hrdata_m, 32'hCAFE_F00D);
        hreset = 1'b0;

        // Single master request then one SINGLE write
        hbusreq_m = 2'b01;
        tick();
        chk("a_grant", 32'(hgrant_m), 32'h1);
        drv(0, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0000_0010);
        #1;
        chk("a_haddr", haddr, 32'h0000_0010);
        chk("a_htrans", 32'(htrans), 32'(HTRANS_NONSEQ));
        chk("a_hwrite", 32'(hwrite), 32'h1);
        tick();
        chk("a_grant2", 32'(hgrant_m), 32'h1);
        chk("a_hwdata", hwdata, wd(0, 32'h10));

        // Both request SINGLEs: strict alternation
        hbusreq_m = 2'b11;
        drv(0, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0000_0020);
        drv(1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0000_0040);
        tick();
        chk("b_grant1", 32'(hgrant_m), 32'h2);
        chk("b_haddr1", haddr, 32'h0000_0040);
        chk("b_hwdata1", hwdata, wd(0, 32'h20));
        tick();
        chk("b_grant2", 32'(hgrant_m), 32'h1);
        chk("b_hwdata2", hwdata, wd(1, 32'h40));
        tick();
        chk("b_grant3", 32'(hgrant_m), 32'h2);
        tick();
        chk("b_grant4", 32'(hgrant_m), 32'h1);

        // Master 0 INCR4 holds the bus against master 1
        drv(0, HTRANS_NONSEQ, HBURST_INCR4, 32'h0000_0100);
        #1;
        chk("c_haddr0", haddr, 32'h0000_0100);
        tick();
        chk("c_grant0", 32'(hgrant_m), 32'h1);
        chk("c_beat0", 32'(dut.beat_q), 32'h3);
        chk("c_state0", 32'(dut.state_q), 32'(LOCK));
        for (int b = 1; b < 4; b++) begin
            drv(0, HTRANS_SEQ, HBURST_INCR4, 32'h0000_0100 + 32'(4 * b));
            #1;
            chk("c_haddr", haddr, 32'h0000_0100 + 32'(4 * b));
            tick();
            chk("c_grant", 32'(hgrant_m), (b == 3) ? 32'h2 : 32'h1);
        end
        chk("c_beat_end", 32'(dut.beat_q), 32'h0);
        chk("c_hwdata_last", hwdata, wd(0, 32'h10C));
        drv(0, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0000_0020);

        // Master 1 INCR4 with a 3-cycle wait state on beat 2
        drv(1, HTRANS_NONSEQ, HBURST_INCR4, 32'h0000_0200);
        tick();
        chk("d_grant0", 32'(hgrant_m), 32'h2);
        chk("d_beat0", 32'(dut.beat_q), 32'h3);
        drv(1, HTRANS_SEQ, HBURST_INCR4, 32'h0000_0204);
        hready = 1'b0;
        #1;
        chk("d_hready_m", 32'(hready_m), 32'h0);
        for (int w = 0; w < 3; w++) begin
            tick();
            chk("d_wait_hmaster", 32'(hmaster), 32'h1);
            chk("d_wait_beat", 32'(dut.beat_q), 32'h3);
            chk("d_wait_hwdata", hwdata, wd(1, 32'h204));
        end
        hready = 1'b1;
        tick();
        chk("d_beat2", 32'(dut.beat_q), 32'h2);
        drv(1, HTRANS_SEQ, HBURST_INCR4, 32'h0000_0208);
        tick();
        chk("d_grant3", 32'(hgrant_m), 32'h2);
        drv(1, HTRANS_SEQ, HBURST_INCR4, 32'h0000_020C);
        tick();
        chk("d_grant4", 32'(hgrant_m), 32'h1);
        chk("d_beat4", 32'(dut.beat_q), 32'h0);
        drv(1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0000_0040);

        // Master 0 INCR (undefined length) drops its request during beat 6
        drv(0, HTRANS_NONSEQ, HBURST_INCR, 32'h0000_0300);
        tick();
        chk("e_grant1", 32'(hgrant_m), 32'h1);
        chk("e_state1", 32'(dut.state_q), 32'(LOCK));
        for (int b = 1; b < 5; b++) begin
            drv(0, HTRANS_SEQ, HBURST_INCR, 32'h0000_0300 + 32'(4 * b));
            tick();
            chk("e_grant_hold", 32'(hgrant_m), 32'h1);
        end
        drv(0, HTRANS_SEQ, HBURST_INCR, 32'h0000_0314);
        hbusreq_m = 2'b10;
        tick();
        chk("e_grant_rel", 32'(hgrant_m), 32'h2);
        chk("e_state_rel", 32'(dut.state_q), 32'(ARB));

        // BUSY keeps the lock; ERROR response clears it without moving grant
        hbusreq_m = 2'b11;
        drv(0, HTRANS_IDLE, HBURST_SINGLE, 32'h0000_0000);
        drv(1, HTRANS_NONSEQ, HBURST_INCR8, 32'h0000_0400);
        tick();
        chk("f_beat0", 32'(dut.beat_q), 32'h7);
        drv(1, HTRANS_BUSY, HBURST_INCR8, 32'h0000_0404);
        tick();
        chk("f_busy_beat", 32'(dut.beat_q), 32'h7);
        chk("f_busy_grant", 32'(hgrant_m), 32'h2);
        drv(1, HTRANS_SEQ, HBURST_INCR8, 32'h0000_0404);
        hready = 1'b0;
        hresp  = HRESP_ERROR;
        #1;
        chk("f_hresp_m", 32'(hresp_m), 32'(HRESP_ERROR));
        tick();
        chk("f_err_beat", 32'(dut.beat_q), 32'h0);
        chk("f_err_state", 32'(dut.state_q), 32'(ARB));
        chk("f_err_grant", 32'(hgrant_m), 32'h2);
        hready = 1'b1;
        hresp  = HRESP_OKAY;
        drv(1, HTRANS_IDLE, HBURST_SINGLE, 32'h0000_0000);
        tick();
        chk("f_grant_after", 32'(hgrant_m), 32'h1);

        // Reset in the middle of a master 1 burst
        hbusreq_m = 2'b10;
        drv(0, HTRANS_IDLE, HBURST_SINGLE, 32'h0000_0600);
        tick();
        chk("g_grant0", 32'(hgrant_m), 32'h2);
        drv(1, HTRANS_NONSEQ, HBURST_INCR4, 32'h0000_0500);
        tick();
        drv(1, HTRANS_SEQ, HBURST_INCR4, 32'h0000_0504);
        tick();
        chk("g_beat_mid", 32'(dut.beat_q), 32'h2);
        chk("g_state_mid", 32'(dut.state_q), 32'(LOCK));
        hreset = 1'b1;
        tick();
        chk("g_rst_grant", 32'(hgrant_m), 32'h1);
        chk("g_rst_hmaster", 32'(hmaster), 32'h0);
        chk("g_rst_beat", 32'(dut.beat_q), 32'h0);
        chk("g_rst_state", 32'(dut.state_q), 32'(ARB));
        chk("g_rst_haddr", haddr, 32'h0000_0600);
        hreset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
